// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register with load extraction, misalignment suppression and retire counter
// Loads that would fault are dropped here: no register write, no retire, one-cycle error pulse.
module mem_wb_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            flush,
   input  logic            EX_MEM_valid,
   input  logic            EX_MEM_regWrite,
   input  logic [4:0]      EX_MEM_Rd,
   input  logic            EX_MEM_memRead,
   input  logic [1:0]      EX_MEM_wbSel,
   input  logic [2:0]      EX_MEM_funct3,
   input  logic [1:0]      EX_MEM_addrLow,
   input  logic [XLEN-1:0] EX_MEM_aluResult,
   input  logic [XLEN-1:0] EX_MEM_pcPlus4,
   input  logic [XLEN-1:0] EX_MEM_imm,
   input  logic [XLEN-1:0] mem_rdata,
   output logic            MEM_WB_valid,
   output logic            MEM_WB_regWrite,
   output logic [4:0]      MEM_WB_Rd,
   output logic [XLEN-1:0] MEM_WB_wdata,
   output logic            misaligned_err,
   output logic [63:0]     retired_count
);

   logic            valid_q, valid_d;
   logic            reg_write_q, reg_write_d;
   logic [4:0]      rd_q, rd_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic            err_q, err_d;
   logic [63:0]     retired_q, retired_d;

   logic            suppress;
   logic [7:0]      byte_lane;
   logic [15:0]     half_lane;
   logic [XLEN-1:0] load_val;
   logic [XLEN-1:0] wb_val;

   always_comb begin
      suppress = 1'b0;
      if (EX_MEM_memRead) begin
         case (EX_MEM_funct3)
            3'b001, 3'b101: suppress = EX_MEM_addrLow[0];
            3'b010:         suppress = (EX_MEM_addrLow != 2'b00);
            3'b011, 3'b110, 3'b111: suppress = 1'b1;
            default:        suppress = 1'b0;
         endcase
      end
   end

   always_comb begin
      byte_lane = 8'h00;
      case (EX_MEM_addrLow)
         2'b00:   byte_lane = mem_rdata[7:0];
         2'b01:   byte_lane = mem_rdata[15:8];
         2'b10:   byte_lane = mem_rdata[23:16];
         default: byte_lane = mem_rdata[31:24];
      endcase
      half_lane = EX_MEM_addrLow[1] ? mem_rdata[31:16] : mem_rdata[15:0];
   end

   // Illegal or misaligned loads produce zero rather than partially-extracted data.
   always_comb begin
      load_val = '0;
      if (!suppress) begin
         case (EX_MEM_funct3)
            3'b000:  load_val = {{(XLEN-8){byte_lane[7]}}, byte_lane};
            3'b001:  load_val = {{(XLEN-16){half_lane[15]}}, half_lane};
            3'b010:  load_val = mem_rdata;
            3'b100:  load_val = {{(XLEN-8){1'b0}}, byte_lane};
            3'b101:  load_val = {{(XLEN-16){1'b0}}, half_lane};
            default: load_val = '0;
         endcase
      end
   end

   always_comb begin
      wb_val = EX_MEM_aluResult;
      case (EX_MEM_wbSel)
         2'b00:   wb_val = EX_MEM_aluResult;
         2'b01:   wb_val = load_val;
         2'b10:   wb_val = EX_MEM_pcPlus4;
         default: wb_val = EX_MEM_imm;
      endcase
   end

   // Priority: rst, flush, stall, capture.
   always_comb begin
      valid_d     = valid_q;
      reg_write_d = reg_write_q;
      rd_d        = rd_q;
      wdata_d     = wdata_q;
      err_d       = 1'b0;
      retired_d   = retired_q;
      if (rst) begin
         valid_d     = 1'b0;
         reg_write_d = 1'b0;
         rd_d        = '0;
         wdata_d     = '0;
         retired_d   = '0;
      end else if (flush) begin
         valid_d     = 1'b0;
         reg_write_d = 1'b0;
         rd_d        = '0;
         wdata_d     = '0;
      end else if (!stall) begin
         valid_d     = EX_MEM_valid;
         reg_write_d = EX_MEM_valid & EX_MEM_regWrite & (EX_MEM_Rd != 5'd0) & ~suppress;
         rd_d        = EX_MEM_Rd;
         wdata_d     = wb_val;
         err_d       = EX_MEM_valid & suppress;
         if (EX_MEM_valid && !suppress) begin
            retired_d = retired_q + 64'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      rd_q        <= rd_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      retired_q   <= retired_d;
   end

   assign MEM_WB_valid    = valid_q;
   assign MEM_WB_regWrite = reg_write_q;
   assign MEM_WB_Rd       = rd_q;
   assign MEM_WB_wdata    = wdata_q;
   assign misaligned_err  = err_q;
   assign retired_count   = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - scoreboard bench for mem_wb_stage
// Driver pushes model predictions on each negedge; monitor pops and compares after each posedge.
module tb_mem_wb_stage;

   typedef struct {
      bit        rst, stall, flush, valid, reg_write, mem_read;
      bit [4:0]  rd;
      bit [1:0]  wb_sel, addr_low;
      bit [2:0]  f3;
      bit [31:0] alu, pc4, imm, rdata;
   } stim_t;

   typedef struct {
      bit        valid, reg_write, err;
      bit [4:0]  rd;
      bit [31:0] wdata;
      bit [63:0] count;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, stall, flush;
   logic        ex_valid, ex_reg_write, ex_mem_read;
   logic [4:0]  ex_rd;
   logic [1:0]  ex_wb_sel, ex_addr_low;
   logic [2:0]  ex_f3;
   logic [31:0] ex_alu, ex_pc4, ex_imm, mem_rdata;
   logic        wb_valid, wb_reg_write, mis_err;
   logic [4:0]  wb_rd;
   logic [31:0] wb_wdata;
   logic [63:0] retired;

   int   checks = 0;
   int   failures = 0;
   exp_t sb_q[$];
   exp_t model;

   always #5 clk = ~clk;

   mem_wb_stage #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .EX_MEM_valid(ex_valid), .EX_MEM_regWrite(ex_reg_write), .EX_MEM_Rd(ex_rd),
      .EX_MEM_memRead(ex_mem_read), .EX_MEM_wbSel(ex_wb_sel), .EX_MEM_funct3(ex_f3),
      .EX_MEM_addrLow(ex_addr_low), .EX_MEM_aluResult(ex_alu), .EX_MEM_pcPlus4(ex_pc4),
      .EX_MEM_imm(ex_imm), .mem_rdata(mem_rdata),
      .MEM_WB_valid(wb_valid), .MEM_WB_regWrite(wb_reg_write), .MEM_WB_Rd(wb_rd),
      .MEM_WB_wdata(wb_wdata), .misaligned_err(mis_err), .retired_count(retired)
   );

   function automatic bit faults(stim_t s);
      if (!s.mem_read) return 1'b0;
      if (s.f3 == 3 || s.f3 == 6 || s.f3 == 7) return 1'b1;
      if ((s.f3 == 1 || s.f3 == 5) && (s.addr_low % 2 == 1)) return 1'b1;
      if (s.f3 == 2 && s.addr_low != 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit [31:0] loaded(stim_t s);
      bit [31:0] b, h;
      b = (s.rdata >> (8 * s.addr_low)) % 256;
      h = (s.rdata >> (16 * (s.addr_low / 2))) % 65536;
      if (faults(s)) return 32'd0;
      case (s.f3)
         3'd0:    return (b >= 128) ? b - 32'd256 : b;
         3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
         3'd2:    return s.rdata;
         3'd4:    return b;
         3'd5:    return h;
         default: return 32'd0;
      endcase
   endfunction

   function automatic exp_t predict(exp_t cur, stim_t s);
      exp_t n = cur;
      n.err = 1'b0;
      if (s.rst) begin
         n = '{default: 0};
      end else if (s.flush) begin
         n.valid = 0; n.reg_write = 0; n.rd = 0; n.wdata = 0;
      end else if (!s.stall) begin
         n.valid     = s.valid;
         n.rd        = s.rd;
         n.reg_write = s.valid && s.reg_write && s.rd != 0 && !faults(s);
         n.err       = s.valid && faults(s);
         case (s.wb_sel)
            2'd0: n.wdata = s.alu;
            2'd1: n.wdata = loaded(s);
            2'd2: n.wdata = s.pc4;
            default: n.wdata = s.imm;
         endcase
         if (s.valid && !faults(s)) n.count = cur.count + 64'd1;
      end
      return n;
   endfunction

   task automatic apply(stim_t s);
      rst = s.rst; stall = s.stall; flush = s.flush;
      ex_valid = s.valid; ex_reg_write = s.reg_write; ex_rd = s.rd;
      ex_mem_read = s.mem_read; ex_wb_sel = s.wb_sel; ex_f3 = s.f3;
      ex_addr_low = s.addr_low; ex_alu = s.alu; ex_pc4 = s.pc4; ex_imm = s.imm;
      mem_rdata = s.rdata;
      model = predict(model, s);
      sb_q.push_back(model);
      @(negedge clk);
   endtask

   function automatic stim_t idle();
      stim_t s = '{default: 0};
      return s;
   endfunction

   function automatic stim_t load(bit [2:0] f3, bit [1:0] al, bit [31:0] rdata, bit [4:0] rd);
      stim_t s = idle();
      s.valid = 1; s.reg_write = 1; s.mem_read = 1; s.wb_sel = 2'd1;
      s.f3 = f3; s.addr_low = al; s.rdata = rdata; s.rd = rd;
      return s;
   endfunction

   task automatic check(string name, bit [63:0] act, bit [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("valid", {63'd0, wb_valid}, {63'd0, e.valid});
            check("regWrite", {63'd0, wb_reg_write}, {63'd0, e.reg_write});
            check("Rd", {59'd0, wb_rd}, {59'd0, e.rd});
            check("wdata", {32'd0, wb_wdata}, {32'd0, e.wdata});
            check("misaligned_err", {63'd0, mis_err}, {63'd0, e.err});
            check("retired_count", retired, e.count);
         end
      end
   end

   initial begin : driver
      stim_t s;
      model = '{default: 0};
      s = idle(); s.rst = 1; s.valid = 1; s.reg_write = 1; s.rd = 9;
      apply(s);
      apply(s);
      // Directed: sign/zero extension, misaligned LW, Rd=0 write.
      apply(load(3'd0, 2'd3, 32'h80FF_1234, 5'd5));
      apply(load(3'd5, 2'd2, 32'hBEEF_0000, 5'd6));
      apply(load(3'd1, 2'd2, 32'hBEEF_0000, 5'd6));
      apply(load(3'd2, 2'd1, 32'hDEAD_BEEF, 5'd7));
      apply(load(3'd1, 2'd1, 32'h1234_5678, 5'd8));
      apply(load(3'd6, 2'd0, 32'h1234_5678, 5'd8));
      s = idle(); s.valid = 1; s.reg_write = 1; s.rd = 0; s.wb_sel = 2'd2; s.pc4 = 32'h100;
      apply(s);
      // Capture then stall with changing inputs, then stall+flush together.
      s = idle(); s.valid = 1; s.reg_write = 1; s.rd = 3; s.alu = 32'h1234;
      apply(s);
      for (int i = 0; i < 3; i++) begin
         s = idle(); s.stall = 1; s.valid = 1; s.reg_write = 1;
         s.rd = 5'(10 + i); s.alu = $urandom; s.wb_sel = 2'(i);
         apply(s);
      end
      s.flush = 1;
      apply(s);
      // Counter wrap from all-ones, then reset during a valid capture.
      rst = 1'b0; stall = 1'b0; flush = 1'b0; ex_valid = 1'b0;
      dut.retired_q = 64'hFFFF_FFFF_FFFF_FFFF;
      model.count = 64'hFFFF_FFFF_FFFF_FFFF;
      s = idle(); s.valid = 1; s.reg_write = 1; s.rd = 4; s.wb_sel = 2'd3; s.imm = 32'hCAFE;
      apply(s);
      apply(s);
      s.rst = 1; s.stall = 1;
      apply(s);
      s.rst = 0; s.stall = 0;
      apply(s);
      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         s.rst       = ($urandom_range(0, 49) == 0);
         s.flush     = ($urandom_range(0, 11) == 0);
         s.stall     = ($urandom_range(0, 7) == 0);
         s.valid     = ($urandom_range(0, 4) != 0);
         s.reg_write = $urandom;
         s.rd        = $urandom;
         s.wb_sel    = $urandom;
         s.mem_read  = (s.wb_sel == 2'd1) || ($urandom_range(0, 3) == 0);
         s.f3        = $urandom;
         s.addr_low  = $urandom;
         s.alu       = $urandom;
         s.pc4       = $urandom;
         s.imm       = $urandom;
         s.rdata     = $urandom;
         apply(s);
      end
      apply(idle());
      repeat (3) @(negedge clk);
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d entries left expected 0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
